// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// with a timed memory handshake, bne support and illegal-opcode trapping.
module multicycle_control #(
    parameter int OPCODE_W        = 6,
    parameter int MEM_TIMEOUT     = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] op_code,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_eq,
    output logic                pc_write_ne,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_zero,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  M_ADDR = 4'd2,  M_RD   = 4'd3,
        M_WB   = 4'd4,  M_WR   = 4'd5,  R_EXEC = 4'd6,  R_WB   = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  I_EXEC = 4'd10, I_WB   = 4'd11,
        TRAP   = 4'd12
    } stateT;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);

    localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    stateT               stateReg;
    logic [7:0]          waitCnt;
    logic [OPCODE_W-1:0] opLatch;
    logic                illegalFlag;
    logic                timeoutFlag;
    logic                inWait;
    logic                stallTimeout;

    assign inWait       = (stateReg == FETCH) || (stateReg == M_RD) || (stateReg == M_WR);
    // A ready on the last allowed cycle still completes normally.
    assign stallTimeout = TIMEOUT_EN && inWait && !mem_ready && (waitCnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= FETCH;
            waitCnt     <= 8'd0;
            opLatch     <= '0;
            illegalFlag <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            waitCnt <= (inWait && !mem_ready && !stallTimeout) ? 8'(waitCnt + 8'd1) : 8'd0;
            if (stallTimeout) begin
                stateReg    <= TRAP;
                timeoutFlag <= 1'b1;
            end else begin
                case (stateReg)
                    FETCH:  if (mem_ready) stateReg <= DECODE;
                    DECODE: begin
                        opLatch <= op_code;
                        case (op_code)
                            OP_RTYPE:        stateReg <= R_EXEC;
                            OP_LW, OP_SW:    stateReg <= M_ADDR;
                            OP_BEQ, OP_BNE:  stateReg <= BRANCH;
                            OP_J:            stateReg <= JUMP;
                            OP_ADDI, OP_ANDI: stateReg <= I_EXEC;
                            default: begin
                                if (TRAP_ON_ILLEGAL) begin
                                    stateReg    <= TRAP;
                                    illegalFlag <= 1'b1;
                                end else begin
                                    stateReg <= FETCH;
                                end
                            end
                        endcase
                    end
                    M_ADDR: stateReg <= (opLatch == OP_LW) ? M_RD : M_WR;
                    M_RD:   if (mem_ready) stateReg <= M_WB;
                    M_WR:   if (mem_ready) stateReg <= FETCH;
                    R_EXEC: stateReg <= R_WB;
                    I_EXEC: stateReg <= I_WB;
                    TRAP:   stateReg <= TRAP;
                    default: stateReg <= FETCH;
                endcase
            end
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ext_zero    = 1'b0;
        alu_op      = 2'b00;
        pc_source   = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        state       = 4'd0;
        if (!rst) begin
            illegal_op  = illegalFlag;
            mem_timeout = timeoutFlag;
            state       = stateReg;
            case (stateReg)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'b11;
                M_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                M_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                M_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                M_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_op      = 2'b01;
                    pc_source   = 2'b01;
                    pc_write_eq = (opLatch == OP_BEQ);
                    pc_write_ne = (opLatch == OP_BNE);
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_zero  = (opLatch == OP_ANDI);
                    alu_op    = (opLatch == OP_ANDI) ? 2'b11 : 2'b00;
                end
                I_WB: begin
                    reg_write = 1'b1;
                    ext_zero  = (opLatch == OP_ANDI);
                    alu_op    = (opLatch == OP_ANDI) ? 2'b11 : 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written corner sequences,
// and random instruction streams checked against a phase-list reference model.
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MRD = 3, S_MWB = 4, S_MWR = 5;
    localparam int S_REXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9, S_IEXEC = 10, S_IWB = 11;
    localparam int S_TRAP = 12;
    localparam logic [5:0] JUNK = 6'h3F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A traps on timeout after 4 cycles and on illegal opcodes.
    logic       rstA = 1'b1, mrA = 1'b0;
    logic [5:0] opA = 6'd0;
    logic       pwA, peqA, pneA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA, saA, ezA, illA, tmoA;
    logic [1:0] sbA, aopA, psA;
    logic [3:0] stA;
    logic [23:0] outA;

    // Instance B waits forever and treats illegal opcodes as NOPs.
    logic       rstB = 1'b1, mrB = 1'b0;
    logic [5:0] opB = 6'd0;
    logic       pwB, peqB, pneB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB, saB, ezB, illB, tmoB;
    logic [1:0] sbB, aopB, psB;
    logic [3:0] stB;
    logic [23:0] outB;

    multicycle_control #(.OPCODE_W(6), .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1)) dutA (
        .clk(clk), .rst(rstA), .op_code(opA), .mem_ready(mrA),
        .pc_write(pwA), .pc_write_eq(peqA), .pc_write_ne(pneA), .iord(iordA),
        .mem_read(mrdA), .mem_write(mwrA), .ir_write(irwA), .mem_to_reg(m2rA),
        .reg_dst(rdstA), .reg_write(rwA), .alu_src_a(saA), .alu_src_b(sbA),
        .ext_zero(ezA), .alu_op(aopA), .pc_source(psA), .illegal_op(illA),
        .mem_timeout(tmoA), .state(stA)
    );

    multicycle_control #(.OPCODE_W(6), .MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b0)) dutB (
        .clk(clk), .rst(rstB), .op_code(opB), .mem_ready(mrB),
        .pc_write(pwB), .pc_write_eq(peqB), .pc_write_ne(pneB), .iord(iordB),
        .mem_read(mrdB), .mem_write(mwrB), .ir_write(irwB), .mem_to_reg(m2rB),
        .reg_dst(rdstB), .reg_write(rwB), .alu_src_a(saB), .alu_src_b(sbB),
        .ext_zero(ezB), .alu_op(aopB), .pc_source(psB), .illegal_op(illB),
        .mem_timeout(tmoB), .state(stB)
    );

    assign outA = {pwA, peqA, pneA, iordA, mrdA, mwrA, irwA, m2rA, rdstA, rwA, saA,
                   sbA, ezA, aopA, psA, illA, tmoA, stA};
    assign outB = {pwB, peqB, pneB, iordB, mrdB, mwrB, irwB, m2rB, rdstB, rwB, saB,
                   sbB, ezB, aopB, psB, illB, tmoB, stB};

    int total = 0;
    int bad = 0;

    // Expected outputs for a given phase, straight from the per-state output table.
    function automatic logic [23:0] specOut(input int st, input logic [5:0] iop, input logic mr,
                                            input logic ill, input logic tmo, input logic r);
        logic pw = 0, peq = 0, pne = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ez = 0;
        logic [1:0] sb = 0, aop = 0, ps = 0;
        if (r) return 24'd0;
        case (st)
            S_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE: sb = 2'b11;
            S_MADDR:  begin sa = 1; sb = 2'b10; end
            S_MRD:    begin mrd = 1; io = 1; end
            S_MWB:    begin rw = 1; m2r = 1; end
            S_MWR:    begin mwr = 1; io = 1; end
            S_REXEC:  begin sa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rd = 1; end
            S_BRANCH: begin sa = 1; aop = 2'b01; ps = 2'b01; peq = (iop == 6'h04); pne = (iop == 6'h05); end
            S_JUMP:   begin pw = 1; ps = 2'b10; end
            S_IEXEC:  begin sa = 1; sb = 2'b10; ez = (iop == 6'h0C); aop = (iop == 6'h0C) ? 2'b11 : 2'b00; end
            S_IWB:    begin rw = 1; ez = (iop == 6'h0C); aop = (iop == 6'h0C) ? 2'b11 : 2'b00; end
            default: ;
        endcase
        return {pw, peq, pne, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ez, aop, ps, ill, tmo, 4'(st)};
    endfunction

    // One cycle: drive inputs after the falling edge, compare before the rising edge.
    task automatic step(input bit sel, input logic r, input logic [5:0] op, input logic mr,
                        input logic [23:0] exp, input string name);
        logic [23:0] got;
        @(negedge clk);
        if (!sel) begin rstA = r; opA = op; mrA = mr; end
        else      begin rstB = r; opB = op; mrB = mr; end
        #1;
        got = sel ? outB : outA;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %h want %h (state got %0d want %0d)",
                     name, $time, got, exp, got[3:0], exp[3:0]);
        end
    endtask

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic       mr;
        int         st;
        logic [5:0] iop;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(input logic r, input logic [5:0] op, input logic mr,
                                 input int st, input logic [5:0] iop);
        vec_t v;
        v.r = r; v.op = op; v.mr = mr; v.st = st; v.iop = iop;
        return v;
    endfunction

    // Random-stream scoreboard.
    typedef struct {
        logic [5:0] op;
        logic       mr;
    } stim_t;
    stim_t       stim_q[$];
    logic [23:0] exp_q[$];

    task automatic pushStep(input logic [5:0] op, input logic mr, input int st, input logic [5:0] iop);
        stim_t s;
        s.op = op; s.mr = mr;
        stim_q.push_back(s);
        exp_q.push_back(specOut(st, iop, mr, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic pushWait(input int st, input logic [5:0] iop, input int stalls);
        for (int k = 0; k < stalls; k++) pushStep(6'($urandom), 1'b0, st, iop);
        pushStep(6'($urandom), 1'b1, st, iop);
    endtask

    // An instruction is a list of phases determined by its class; wait phases stretch by the stall count.
    task automatic pushInsn(input logic [5:0] op);
        pushWait(S_FETCH, op, $urandom_range(0, 3));
        pushStep(op, 1'($urandom), S_DECODE, op);
        case (op)
            6'h00: begin pushStep(6'($urandom), 1'($urandom), S_REXEC, op); pushStep(6'($urandom), 1'($urandom), S_RWB, op); end
            6'h23: begin pushStep(6'($urandom), 1'($urandom), S_MADDR, op); pushWait(S_MRD, op, $urandom_range(0, 3));
                         pushStep(6'($urandom), 1'($urandom), S_MWB, op); end
            6'h2B: begin pushStep(6'($urandom), 1'($urandom), S_MADDR, op); pushWait(S_MWR, op, $urandom_range(0, 3)); end
            6'h04, 6'h05: pushStep(6'($urandom), 1'($urandom), S_BRANCH, op);
            6'h02: pushStep(6'($urandom), 1'($urandom), S_JUMP, op);
            default: begin pushStep(6'($urandom), 1'($urandom), S_IEXEC, op); pushStep(6'($urandom), 1'($urandom), S_IWB, op); end
        endcase
    endtask

    logic [5:0] legal [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C};

    initial begin
        // R-type, lw with a 3-cycle read stall, beq, bne, andi, jump, addi with a fetch stall,
        // then sw interrupted by reset in M_WR.
        vecs.push_back(mkv(1, 6'h00, 1, S_FETCH, 6'h00));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h00));
        vecs.push_back(mkv(0, 6'h00, 1, S_DECODE, 6'h00));
        vecs.push_back(mkv(0, JUNK,  1, S_REXEC,  6'h00));
        vecs.push_back(mkv(0, JUNK,  1, S_RWB,    6'h00));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h23));
        vecs.push_back(mkv(0, 6'h23, 1, S_DECODE, 6'h23));
        vecs.push_back(mkv(0, JUNK,  1, S_MADDR,  6'h23));
        vecs.push_back(mkv(0, JUNK,  0, S_MRD,    6'h23));
        vecs.push_back(mkv(0, JUNK,  0, S_MRD,    6'h23));
        vecs.push_back(mkv(0, JUNK,  0, S_MRD,    6'h23));
        vecs.push_back(mkv(0, JUNK,  1, S_MRD,    6'h23));
        vecs.push_back(mkv(0, JUNK,  1, S_MWB,    6'h23));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h04));
        vecs.push_back(mkv(0, 6'h04, 1, S_DECODE, 6'h04));
        vecs.push_back(mkv(0, 6'h05, 1, S_BRANCH, 6'h04));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h05));
        vecs.push_back(mkv(0, 6'h05, 1, S_DECODE, 6'h05));
        vecs.push_back(mkv(0, 6'h04, 1, S_BRANCH, 6'h05));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h0C));
        vecs.push_back(mkv(0, 6'h0C, 1, S_DECODE, 6'h0C));
        vecs.push_back(mkv(0, 6'h08, 1, S_IEXEC,  6'h0C));
        vecs.push_back(mkv(0, 6'h08, 1, S_IWB,    6'h0C));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h02));
        vecs.push_back(mkv(0, 6'h02, 1, S_DECODE, 6'h02));
        vecs.push_back(mkv(0, JUNK,  1, S_JUMP,   6'h02));
        vecs.push_back(mkv(0, JUNK,  0, S_FETCH,  6'h08));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h08));
        vecs.push_back(mkv(0, 6'h08, 1, S_DECODE, 6'h08));
        vecs.push_back(mkv(0, 6'h0C, 1, S_IEXEC,  6'h08));
        vecs.push_back(mkv(0, 6'h0C, 1, S_IWB,    6'h08));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h2B));
        vecs.push_back(mkv(0, 6'h2B, 1, S_DECODE, 6'h2B));
        vecs.push_back(mkv(0, JUNK,  1, S_MADDR,  6'h2B));
        vecs.push_back(mkv(0, JUNK,  0, S_MWR,    6'h2B));
        vecs.push_back(mkv(1, JUNK,  0, S_MWR,    6'h2B));
        vecs.push_back(mkv(0, JUNK,  0, S_FETCH,  6'h00));
        vecs.push_back(mkv(0, JUNK,  1, S_FETCH,  6'h00));

        foreach (vecs[i])
            step(0, vecs[i].r, vecs[i].op, vecs[i].mr,
                 specOut(vecs[i].st, vecs[i].iop, vecs[i].mr, 1'b0, 1'b0, vecs[i].r), $sformatf("vec%0d", i));

        // Ready arriving on the last allowed fetch cycle completes without a trap.
        step(0, 1, 6'h00, 0, 24'd0, "late_rst");
        for (int k = 0; k < 3; k++) step(0, 0, JUNK, 0, specOut(S_FETCH, 0, 0, 0, 0, 0), "late_stall");
        step(0, 0, JUNK, 1, specOut(S_FETCH, 0, 1, 0, 0, 0), "late_ready");
        step(0, 0, 6'h02, 1, specOut(S_DECODE, 0, 1, 0, 0, 0), "late_decode");

        // Fetch stuck: four stalled cycles, then sticky timeout trap until reset.
        step(0, 1, 6'h00, 0, 24'd0, "tmo_rst");
        for (int k = 0; k < 4; k++) step(0, 0, JUNK, 0, specOut(S_FETCH, 0, 0, 0, 0, 0), "tmo_stall");
        for (int k = 0; k < 3; k++) step(0, 0, 6'h00, 1'(k), specOut(S_TRAP, 0, 1'(k), 0, 1, 0), "tmo_trap");
        step(0, 1, 6'h00, 1, 24'd0, "tmo_clear_rst");
        step(0, 0, JUNK, 1, specOut(S_FETCH, 0, 1, 0, 0, 0), "tmo_cleared");

        // Illegal opcode with trapping enabled.
        step(0, 1, 6'h00, 1, 24'd0, "ill_rst");
        step(0, 0, JUNK, 1, specOut(S_FETCH, 0, 1, 0, 0, 0), "ill_fetch");
        step(0, 0, 6'h3F, 1, specOut(S_DECODE, 0, 1, 0, 0, 0), "ill_decode");
        for (int k = 0; k < 2; k++) step(0, 0, 6'h00, 1, specOut(S_TRAP, 0, 1, 1, 0, 0), "ill_trap");

        // Instance B: no timeout at all, and an illegal opcode behaves as a NOP.
        step(1, 1, 6'h00, 0, 24'd0, "nop_rst");
        for (int k = 0; k < 20; k++) step(1, 0, JUNK, 0, specOut(S_FETCH, 0, 0, 0, 0, 0), "notmo_stall");
        step(1, 0, JUNK, 1, specOut(S_FETCH, 0, 1, 0, 0, 0), "nop_fetch");
        step(1, 0, 6'h3F, 1, specOut(S_DECODE, 0, 1, 0, 0, 0), "nop_decode");
        step(1, 0, JUNK, 1, specOut(S_FETCH, 0, 1, 0, 0, 0), "nop_back");

        // Random legal instruction stream on instance A.
        step(0, 1, 6'h00, 1, 24'd0, "rnd_rst");
        for (int n = 0; n < 60; n++) pushInsn(legal[$urandom_range(0, 7)]);
        while (stim_q.size() > 0) begin
            stim_t s;
            logic [23:0] e;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            step(0, 0, s.op, s.mr, e, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
